// File: rtl/interrupt_controller.sv
// Interrupt aggregator for the PWM carrier channels: sticky per-channel pending with edge/level capture,
// mask, W1C clear, and a registered irq line plus the lowest-index active source. Optional macro: INTC_COALESCE_EN.
module interrupt_controller #(
  parameter int N_CH = 8,
`ifdef INTC_COALESCE_EN
  parameter int CNT_W = 16,
`endif
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   irq_in,
  input  logic [N_CH-1:0]   mask,
  input  logic [N_CH-1:0]   mode,
  input  logic [N_CH-1:0]   clr,
`ifdef INTC_COALESCE_EN
  input  logic [CNT_W-1:0]  coal_thresh,
  input  logic [CNT_W-1:0]  coal_timeout,
`endif
  output logic [N_CH-1:0]   pending_out,
  output logic              irq_out,
  output logic [ID_W-1:0]   irq_id
);

  logic [N_CH-1:0] irq_d;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] pending_nxt;
  logic [N_CH-1:0] act;
  logic            any_act;
  logic [ID_W-1:0] enc;
  logic            irq_nxt;

  // Level mode ignores the delay register; edge mode needs a low-to-high transition.
  assign ev          = irq_in & (mode | ~irq_d);
  assign pending_nxt = (pending & ~clr) | ev;
  assign act         = pending & mask;
  assign any_act     = |act;
  assign pending_out = pending;

  always_comb begin
    enc = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (act[i]) enc = ID_W'(i);
    end
  end

`ifdef INTC_COALESCE_EN
  // state  | meaning
  // IDLE   | no masked activity being accumulated
  // ACCUM  | counting masked events and cycles since the first one
  // FIRE   | irq_out follows the masked pending vector until it empties
  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} coal_state_t;

  coal_state_t      state, state_nxt;
  logic [CNT_W-1:0] ev_cnt, ev_cnt_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] thresh_eff;
  logic             masked_ev;
  logic             fire_cond;

  assign masked_ev  = |(ev & mask);
  assign thresh_eff = (coal_thresh == '0) ? CNT_W'(1) : coal_thresh;
  assign fire_cond  = (ev_cnt >= thresh_eff) ||
                      ((coal_timeout != '0) && (tmr == coal_timeout));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ev_cnt <= '0;
      tmr    <= '0;
    end else begin
      state  <= state_nxt;
      ev_cnt <= ev_cnt_nxt;
      tmr    <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ev_cnt_nxt = ev_cnt;
    tmr_nxt    = tmr;
    case (state)
      IDLE: begin
        if (masked_ev) begin
          state_nxt  = ACCUM;
          ev_cnt_nxt = CNT_W'(1);
          tmr_nxt    = '0;
        end
      end
      ACCUM: begin
        tmr_nxt = tmr + 1'b1;
        if (masked_ev && (ev_cnt != '1)) ev_cnt_nxt = ev_cnt + 1'b1;
        // Pending drained by software before the threshold was reached: drop the burst silently.
        if (!any_act && !masked_ev) begin
          state_nxt  = IDLE;
          ev_cnt_nxt = '0;
          tmr_nxt    = '0;
        end else if (fire_cond) begin
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (!any_act) begin
          state_nxt  = IDLE;
          ev_cnt_nxt = '0;
          tmr_nxt    = '0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        ev_cnt_nxt = '0;
        tmr_nxt    = '0;
      end
    endcase
  end

  assign irq_nxt = (state_nxt == FIRE) && any_act;
`else
  assign irq_nxt = any_act;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_d   <= '1;
      pending <= '0;
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_d   <= irq_in;
      pending <= pending_nxt;
      irq_out <= irq_nxt;
      irq_id  <= irq_nxt ? enc : '0;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (N_CH=8, default build).
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] mode;
  logic [7:0] clr;
  logic [7:0] pending_out;
  logic       irq_out;
  logic [2:0] irq_id;
  int         checks = 0;
  int         errors = 0;

`ifdef INTC_COALESCE_EN
  logic [15:0] coal_thresh  = 16'd1;
  logic [15:0] coal_timeout = 16'd0;
`endif

  interrupt_controller #(.N_CH(8)) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .mask(mask),
    .mode(mode),
    .clr(clr),
`ifdef INTC_COALESCE_EN
    .coal_thresh(coal_thresh),
    .coal_timeout(coal_timeout),
`endif
    .pending_out(pending_out),
    .irq_out(irq_out),
    .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; irq_in = 8'h00; mask = 8'h00; mode = 8'h00; clr = 8'h00;
    step(2);
    checks++;
    if (pending_out !== 8'h00 || irq_out !== 1'b0 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: pend=%h irq=%b id=%0d, want 00/0/0", pending_out, irq_out, irq_id);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_edge_capture;
    mask = 8'hFF; mode = 8'h00;
    irq_in = 8'h08;
    step();
    checks++;
    if (pending_out !== 8'h08 || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL edge_pend: pend=%h irq=%b, want 08/0", pending_out, irq_out);
    end
    irq_in = 8'h00;
    step();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd3) begin
      errors++;
      $display("FAIL edge_irq: irq=%b id=%0d, want 1/3", irq_out, irq_id);
    end
    clr = 8'h08;
    step();
    clr = 8'h00;
    checks++;
    if (pending_out !== 8'h00 || irq_out !== 1'b1) begin
      errors++;
      $display("FAIL edge_clr_pend: pend=%h irq=%b, want 00/1", pending_out, irq_out);
    end
    step();
    checks++;
    if (irq_out !== 1'b0 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL edge_clr_irq: irq=%b id=%0d, want 0/0", irq_out, irq_id);
    end
  endtask

  task automatic test_reset_suppression;
    reset = 1'b1; irq_in = 8'hFF; mode = 8'h00; mask = 8'hFF;
    step(2);
    reset = 1'b0;
    step(3);
    checks++;
    if (pending_out !== 8'h00 || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_suppress: pend=%h irq=%b, want 00/0", pending_out, irq_out);
    end
    irq_in = 8'h00;
    step(2);
  endtask

  task automatic test_priority_mask;
    mask = 8'h3C; mode = 8'h00;
    irq_in = 8'h26;
    step();
    irq_in = 8'h00;
    checks++;
    if (pending_out !== 8'h26) begin
      errors++;
      $display("FAIL prio_pend: pend=%h, want 26", pending_out);
    end
    step();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd2) begin
      errors++;
      $display("FAIL prio_id: irq=%b id=%0d, want 1/2", irq_out, irq_id);
    end
    clr = 8'h04;
    step();
    clr = 8'h00;
    step();
    checks++;
    if (pending_out !== 8'h22 || irq_out !== 1'b1 || irq_id !== 3'd5) begin
      errors++;
      $display("FAIL prio_after_clr: pend=%h irq=%b id=%0d, want 22/1/5", pending_out, irq_out, irq_id);
    end
    clr = 8'h20;
    step();
    clr = 8'h00;
    step();
    checks++;
    if (pending_out !== 8'h02 || irq_out !== 1'b0 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL prio_masked_only: pend=%h irq=%b id=%0d, want 02/0/0", pending_out, irq_out, irq_id);
    end
    clr = 8'hFF;
    step();
    clr = 8'h00;
    step();
  endtask

  task automatic test_level_reassert;
    mask = 8'hFF; mode = 8'h01;
    irq_in = 8'h01;
    step(2);
    checks++;
    if (pending_out !== 8'h01 || irq_out !== 1'b1 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL level_set: pend=%h irq=%b id=%0d, want 01/1/0", pending_out, irq_out, irq_id);
    end
    clr = 8'h01;
    step();
    clr = 8'h00;
    checks++;
    if (pending_out !== 8'h01 || irq_out !== 1'b1) begin
      errors++;
      $display("FAIL level_hold: pend=%h irq=%b, want 01/1", pending_out, irq_out);
    end
    step();
    checks++;
    if (irq_out !== 1'b1) begin
      errors++;
      $display("FAIL level_hold_irq: irq=%b, want 1", irq_out);
    end
    irq_in = 8'h00;
    step();
    checks++;
    if (pending_out !== 8'h01) begin
      errors++;
      $display("FAIL level_sticky: pend=%h, want 01", pending_out);
    end
    clr = 8'h01;
    step();
    clr = 8'h00;
    step();
    checks++;
    if (pending_out !== 8'h00 || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL level_clear: pend=%h irq=%b, want 00/0", pending_out, irq_out);
    end
    mode = 8'h00;
  endtask

  task automatic test_collision;
    mask = 8'h00; mode = 8'h00;
    irq_in = 8'h40; clr = 8'h40;
    step();
    irq_in = 8'h00; clr = 8'h00;
    checks++;
    if (pending_out !== 8'h40) begin
      errors++;
      $display("FAIL collide_pend: pend=%h, want 40", pending_out);
    end
    step();
    checks++;
    if (irq_out !== 1'b0) begin
      errors++;
      $display("FAIL collide_masked: irq=%b, want 0", irq_out);
    end
    mask = 8'h40;
    step();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd6) begin
      errors++;
      $display("FAIL collide_unmask: irq=%b id=%0d, want 1/6", irq_out, irq_id);
    end
    mask = 8'h00;
    step();
    checks++;
    if (irq_out !== 1'b0 || irq_id !== 3'd0 || pending_out !== 8'h40) begin
      errors++;
      $display("FAIL collide_remask: irq=%b id=%0d pend=%h, want 0/0/40", irq_out, irq_id, pending_out);
    end
    clr = 8'hFF;
    step();
    clr = 8'h00;
  endtask

  task automatic test_mode_change;
    mask = 8'hFF; mode = 8'h00;
    irq_in = 8'h02;
    step();
    clr = 8'h02;
    step();
    clr = 8'h00;
    step();
    checks++;
    if (pending_out !== 8'h00) begin
      errors++;
      $display("FAIL mode_edge_held: pend=%h, want 00", pending_out);
    end
    mode = 8'h02;
    step();
    checks++;
    if (pending_out !== 8'h02) begin
      errors++;
      $display("FAIL mode_to_level: pend=%h, want 02", pending_out);
    end
    irq_in = 8'h00; mode = 8'h00; clr = 8'hFF;
    step();
    clr = 8'h00;
    step();
  endtask

  task automatic test_mid_reset;
    mask = 8'hFF; mode = 8'h00;
    irq_in = 8'h90;
    step(2);
    checks++;
    if (pending_out !== 8'h90 || irq_out !== 1'b1 || irq_id !== 3'd4) begin
      errors++;
      $display("FAIL mid_pre: pend=%h irq=%b id=%0d, want 90/1/4", pending_out, irq_out, irq_id);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pending_out !== 8'h00 || irq_out !== 1'b0 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_async: pend=%h irq=%b id=%0d, want 00/0/0", pending_out, irq_out, irq_id);
    end
    step();
    reset = 1'b0;
    step(3);
    checks++;
    if (pending_out !== 8'h00 || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: pend=%h irq=%b, want 00/0", pending_out, irq_out);
    end
    irq_in = 8'h00;
    step();
    irq_in = 8'h10;
    step(2);
    checks++;
    if (pending_out !== 8'h10 || irq_out !== 1'b1 || irq_id !== 3'd4) begin
      errors++;
      $display("FAIL mid_new_edge: pend=%h irq=%b id=%0d, want 10/1/4", pending_out, irq_out, irq_id);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; irq_in = 8'h00; mask = 8'h00; mode = 8'h00; clr = 8'h00;
    test_reset();
    test_edge_capture();
    test_reset_suppression();
    test_priority_mask();
    test_level_reassert();
    test_collision();
    test_mode_change();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised interrupt aggregator for the PWM carrier channels, one interrupt source per channel.
- Per channel: rising-edge or level capture into a sticky pending register, enable mask, and write-1-to-clear.
- Drives one registered interrupt line to the PS, plus the index of the highest-priority active source.
- Sits between the PWM channel event outputs and the AXI4-Lite register file, which supplies mask, mode and clear.

Parameters:
- N_CH, `PWM_WIDTH, number of interrupt channels (1..32).
- ID_W, $clog2(N_CH) with a minimum of 1, width of irq_id (localparam).
- CNT_W, 16, width of the coalescing counters (used only with INTC_COALESCE_EN).

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  N_CH  raw channel interrupt sources.
- mask  in  N_CH  1 = channel enabled onto irq_out.
- mode  in  N_CH  per channel: 0 = rising-edge capture, 1 = level capture.
- clr  in  N_CH  write-1-to-clear pending, single-cycle strobes from the register file.
- pending_out  out  N_CH  sticky pending register (unmasked view, for status readback).
- irq_out  out  1  aggregated interrupt, registered.
- irq_id  out  ID_W  lowest-numbered masked pending channel; valid only while irq_out=1, otherwise 0.
- coal_thresh  in  CNT_W  event-count threshold (present only with INTC_COALESCE_EN).
- coal_timeout  in  CNT_W  timeout in clk cycles (present only with INTC_COALESCE_EN).

Behaviour:
- Reset values (asynchronous, active-high):
  - pending_out=0, irq_out=0, irq_id=0.
  - Internal irq_in delay register irq_d = all ones, so an input already high at reset release produces no edge event.
- Event detection per channel i, evaluated each cycle:
  - mode[i]=0: ev[i] = irq_in[i] & ~irq_d[i].
  - mode[i]=1: ev[i] = irq_in[i].
  - irq_d <= irq_in every cycle, independent of mode.
- Pending update: pending[i] <= (pending[i] & ~clr[i]) | ev[i].
  - If set and clear coincide, set wins and pending stays 1.
  - In level mode, pending re-asserts on the cycle after a clear for as long as irq_in stays high.
- Latency:
  - irq_in sampled high at edge k gives pending visible after edge k.
  - irq_out and irq_id update after edge k+1.
  - Total 2 cycles from input to irq_out.
- irq_out <= |(pending & mask). irq_id <= priority encode of (pending & mask), lowest index wins.
- Mask does not gate capture; pending sets regardless of mask.
  - Unmasking an already-pending channel asserts irq_out 1 cycle later.
  - Masking it deasserts irq_out 1 cycle later, provided no other channel is active.
- Clearing the last active pending bit at edge k deasserts irq_out after edge k+1.
- A mode change takes effect on the next cycle. Changing edge to level while the input is high sets pending on the next cycle.
- Reset mid-operation drops all pending state immediately. No events are lost or replayed except as defined by the irq_d reset value.

Optional Feature:
- Macro: INTC_COALESCE_EN.
- Defined: irq_out is gated by a coalescing FSM with states IDLE, ACCUM and FIRE.
  - IDLE → ACCUM on the first masked event, with ev_cnt=1 and tmr=0.
  - In ACCUM, ev_cnt counts masked ev cycles and saturates at all ones; tmr increments every cycle.
  - ACCUM → FIRE when ev_cnt >= max(coal_thresh,1), or when coal_timeout != 0 and tmr == coal_timeout.
  - coal_timeout=0 disables the timeout.
  - In FIRE, irq_out follows |(pending & mask).
  - FIRE → IDLE when (pending & mask) becomes 0, with counters cleared.
  - If pending is cleared while in ACCUM, the FSM returns to IDLE without firing.
- Undefined: no coal_* ports and no FSM; irq_out is exactly as in Behaviour.

Test Plan:
- Edge capture, N_CH=8, mode=0x00, mask=0xFF: pulse irq_in[3] for 1 cycle → pending_out=0x08 next cycle, then irq_out=1 and irq_id=3; strobe clr=0x08 → irq_out=0 two cycles after the strobe.
- Reset/edge suppression: hold irq_in=0xFF through reset release with mode=0x00 → pending_out stays 0x00 and irq_out stays 0.
- Priority and mask, mask=0x3C: events on channels 1, 5 and 2 in the same cycle → pending_out=0x26, irq_id=2; then clear bit 2 → irq_id=5.
- Level re-assert: mode[0]=1, irq_in[0] held high, clr=0x01 strobe → pending_out[0] stays 1 and irq_out stays 1; drop irq_in[0], then clr → irq_out=0.
- Set/clear collision: rising edge on channel 6 in the same cycle as clr=0x40 → pending_out[6]=1; with mask=0 → irq_out=0; set mask=0x40 → irq_out=1 one cycle later.
- INTC_COALESCE_EN, coal_thresh=4, coal_timeout=100, one channel event every 10 cycles:
  - irq_out rises 1 cycle after the 4th event.
  - Rerun with coal_thresh=50: irq_out rises at tmr=100.
